if_fetch: RTL and testbench
===========================

# if_fetch

Instruction fetch stage, directly upstream of the memory controller. It holds the PC and issues one 4-byte read per instruction on the controller's fetch port (port 0). Returned words go into a one-entry output buffer with valid/stall handshake toward decode. Branch redirects are accepted at any time. An optional direct-mapped instruction cache bypasses the controller on hits.

## Interface
- RESET_PC, 32'h0, PC loaded at reset (bits [1:0] must be 0)
- clk_in  input  1  clock; all logic on rising edge
- rst_n_in  input  1  synchronous, active-low reset
- rdy_in  input  1  global enable; low = every register holds
- mc_re_out  output  1  read request to controller port 0 (maps to re[0])
- mc_addr_out  output  32  word-aligned fetch address (maps to addr[31:0])
- mc_len_out  output  3  constant 3'd4 (maps to len_in_byte[2:0])
- mc_busy_in  input  1  controller state_busy[0]
- mc_done_in  input  1  controller state_done[0], one-cycle pulse
- mc_r_data_in  input  32  controller r_data[31:0], valid in the mc_done_in cycle
- id_stall_in  input  1  decode cannot accept this cycle
- inst_valid_out  output  1  output buffer holds an instruction
- inst_out  output  32  instruction word
- pc_out  output  32  address of inst_out
- flush_in  input  1  redirect request
- flush_pc_in  input  32  redirect target; bits [1:0] forced to 0

## Operation
- State machine: IDLE, ISSUE, WAIT.
- Buffer free condition: `!inst_valid_out || !id_stall_in`.
- Output consume: when `inst_valid_out && !id_stall_in`, clear `inst_valid_out` unless it is refilled in the same cycle.
- IDLE:
  - If the buffer is free, `!mc_busy_in`, and there is no flush: set `mc_re_out<=1` and `mc_addr_out<={pc[31:2],2'b00}`, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - The controller samples the request this cycle.
  - Set `mc_re_out<=0` and go to WAIT. `mc_re_out` is never high for more than one cycle per fetch.
- WAIT:
  - On `mc_done_in` with `discard==0`: `inst_out<=mc_r_data_in`, `pc_out<=pc`, `inst_valid_out<=1`, `pc<=pc+4` (mod 2^32, wraps from FFFF_FFFC to 0), go to IDLE.
  - On `mc_done_in` with `discard==1`: drop the data, clear `discard`, go to IDLE.
- Buffer invariant: a fetch is issued only when the buffer is free, so the buffer is always empty when `mc_done_in` arrives. No skid buffer is needed.
- Flush (highest priority, any state):
  - `pc<=flush_pc_in&~3` and `inst_valid_out<=0`.
  - In IDLE, no request is issued that cycle.
  - In ISSUE or WAIT, set `discard<=1`. The outstanding controller transaction cannot be cancelled and must complete; its data is dropped.
  - Flush in the same cycle as a non-discarded `mc_done_in`: flush wins. Data is dropped, `pc`=target, go to IDLE.
- `rdy_in==0`: all state, outputs and `discard` hold.
- Reset (`rst_n_in==0` at edge), reset values:
  - `state`=IDLE, `pc`=RESET_PC, `discard`=0
  - `mc_re_out`=0, `mc_addr_out`=0, `mc_len_out`=4
  - `inst_valid_out`=0, `inst_out`=0, `pc_out`=0
  - cache valid bits cleared
- Reset mid-WAIT: the controller is reset by the same system reset, so no stale `mc_done_in` is expected.

## Timing
- Uncached fetch latency, from the IDLE decision edge to `inst_valid_out` high:
  - 1 cycle ISSUE
  - controller latency (4-byte read = 5 controller cycles: RECV_1..RECV_5)
  - `inst_valid_out` rises on the edge after `mc_done_in`
- Steady-state throughput, no stall: one instruction per (controller latency + 2) cycles.
- Cache hit (when enabled): `inst_valid_out` rises on the edge after the IDLE lookup. Back-to-back hits give one instruction per cycle while `id_stall_in==0`.
- `inst_out` and `pc_out` stay stable while `inst_valid_out && id_stall_in`.

## Configuration
- ICACHE_EN defined:
  - 16-entry direct-mapped cache; index `pc[5:2]`, tag `pc[31:6]`, one valid bit per entry.
  - In IDLE with buffer free and hit: load buffer from cache, `pc<=pc+4`, stay IDLE, no controller request.
  - On miss: normal fetch. A non-discarded `mc_done_in` writes data and tag and sets valid for that index.
  - Discarded data is not written.
  - Flush does not invalidate the cache (no self-modifying code support).
- ICACHE_EN undefined: no cache storage; every instruction goes through the controller.

## Test plan
- Reset with RESET_PC=0, memory word0=0x00000013, `id_stall_in`=0 -> exactly one `mc_re_out` pulse with `mc_addr_out`=0, `mc_len_out`=4; then `inst_valid_out`=1, `inst_out`=0x00000013, `pc_out`=0; next request addr=4.
- Hold `id_stall_in`=1 while `inst_valid_out`=1 -> no new `mc_re_out`; `inst_out`/`pc_out` stable; release -> next fetch issues.
- `flush_in` with `flush_pc_in`=0x107 during WAIT -> returned word dropped, `inst_valid_out` stays 0; next request addr=0x104; `pc_out`=0x104 on delivery.
- `flush_in` coincident with `mc_done_in` -> no instruction delivered; next fetch at target.
- `rdy_in` low for 3 cycles mid-WAIT -> no state change; delivery delayed by the same 3 cycles.
- ICACHE_EN: loop of 4 instructions at 0x40..0x4C with flush back to 0x40 -> second iteration issues zero `mc_re_out` pulses and delivers one instruction per cycle.

Source files
------------

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage in front of the memory controller's fetch port.
// Holds the PC, issues one 4-byte read per instruction and presents the returned word
// to decode through a one-entry valid/stall buffer. Redirects (flush) are accepted in
// any state; an in-flight controller read is allowed to finish and its data is dropped.
// Optional feature: define ICACHE_EN to add a 16-entry direct-mapped instruction cache.

module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    // Memory controller fetch port (port 0)
    output logic        mc_re_out,
    output logic [31:0] mc_addr_out,
    output logic [2:0]  mc_len_out,
    input  logic        mc_busy_in,
    input  logic        mc_done_in,
    input  logic [31:0] mc_r_data_in,
    // Decode side
    input  logic        id_stall_in,
    output logic        inst_valid_out,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    // Redirect
    input  logic        flush_in,
    input  logic [31:0] flush_pc_in
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    // ------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------
    state_e      r_state;
    logic [31:0] r_pc;
    logic        r_discard;
    logic        r_mc_re;
    logic [31:0] r_mc_addr;
    logic        r_inst_valid;
    logic [31:0] r_inst;
    logic [31:0] r_pc_out;

    state_e      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_discard_nxt;
    logic        w_mc_re_nxt;
    logic [31:0] w_mc_addr_nxt;
    logic        w_inst_valid_nxt;
    logic [31:0] w_inst_nxt;
    logic [31:0] w_pc_out_nxt;

    logic        w_buf_free;
    logic [31:0] w_flush_pc;
    logic [31:0] w_pc_inc;
    logic        w_hit;
    logic [31:0] w_hit_data;

    // Buffer can take a new word if it is empty or being drained this cycle
    assign w_buf_free = !r_inst_valid || !id_stall_in;
    assign w_flush_pc = flush_pc_in & ~32'h0000_0003;
    // Natural 32-bit wrap: FFFF_FFFC + 4 = 0
    assign w_pc_inc   = r_pc + 32'd4;

    // ------------------------------------------------------------------
    // Optional instruction cache
    // ------------------------------------------------------------------
`ifdef ICACHE_EN
    localparam int unsigned CacheEntries = 16;

    logic [25:0]             r_cache_tag  [CacheEntries];
    logic [31:0]             r_cache_data [CacheEntries];
    logic [CacheEntries-1:0] r_cache_valid;

    logic [3:0]  w_cache_idx;
    logic        w_cache_wr;

    assign w_cache_idx = r_pc[5:2];
    assign w_hit       = r_cache_valid[w_cache_idx] &&
                         (r_cache_tag[w_cache_idx] == r_pc[31:6]);
    assign w_hit_data  = r_cache_data[w_cache_idx];
    // PC is frozen during WAIT, so it still indexes the line being filled.
    // A flush in the done cycle wins, so that data is not cached either.
    assign w_cache_wr  = (r_state == StWait) && mc_done_in && !r_discard && !flush_in;

    // Valid bits: cleared on reset, set on each accepted fill; flush leaves them alone
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_cache_valid <= '0;
        end else if (rdy_in && w_cache_wr) begin
            r_cache_valid[w_cache_idx] <= 1'b1;
        end
    end

    // Tag and data storage, written alongside the valid bit
    always_ff @(posedge clk_in) begin
        if (rst_n_in && rdy_in && w_cache_wr) begin
            r_cache_tag[w_cache_idx]  <= r_pc[31:6];
            r_cache_data[w_cache_idx] <= mc_r_data_in;
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = 32'h0000_0000;
`endif

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    // Fetch FSM: flush has priority over everything, then per-state behaviour
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_discard_nxt    = r_discard;
        w_mc_re_nxt      = r_mc_re;
        w_mc_addr_nxt    = r_mc_addr;
        w_inst_valid_nxt = r_inst_valid;
        w_inst_nxt       = r_inst;
        w_pc_out_nxt     = r_pc_out;

        // Decode takes the word this cycle; a refill below may set it again
        if (r_inst_valid && !id_stall_in) begin
            w_inst_valid_nxt = 1'b0;
        end

        if (flush_in) begin
            w_pc_nxt         = w_flush_pc;
            w_inst_valid_nxt = 1'b0;
            case (r_state)
                StIssue: begin
                    // Controller is sampling the request now; it cannot be withdrawn
                    w_mc_re_nxt   = 1'b0;
                    w_discard_nxt = 1'b1;
                    w_state_nxt   = StWait;
                end
                StWait: begin
                    if (mc_done_in) begin
                        // Outstanding read ends here; nothing left to discard
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = StIdle;
                    end else begin
                        w_discard_nxt = 1'b1;
                    end
                end
                default: begin
                    w_mc_re_nxt = 1'b0;
                    w_state_nxt = StIdle;
                end
            endcase
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_buf_free && w_hit) begin
                        w_inst_nxt       = w_hit_data;
                        w_pc_out_nxt     = r_pc;
                        w_inst_valid_nxt = 1'b1;
                        w_pc_nxt         = w_pc_inc;
                    end else if (w_buf_free && !mc_busy_in) begin
                        w_mc_re_nxt   = 1'b1;
                        w_mc_addr_nxt = {r_pc[31:2], 2'b00};
                        w_state_nxt   = StIssue;
                    end
                end
                StIssue: begin
                    // Request is held for exactly one cycle
                    w_mc_re_nxt = 1'b0;
                    w_state_nxt = StWait;
                end
                StWait: begin
                    if (mc_done_in) begin
                        if (r_discard) begin
                            w_discard_nxt = 1'b0;
                        end else begin
                            // Buffer is guaranteed empty here: fetch only issued when free
                            w_inst_nxt       = mc_r_data_in;
                            w_pc_out_nxt     = r_pc;
                            w_inst_valid_nxt = 1'b1;
                            w_pc_nxt         = w_pc_inc;
                        end
                        w_state_nxt = StIdle;
                    end
                end
                default: begin
                    w_mc_re_nxt = 1'b0;
                    w_state_nxt = StIdle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // Synchronous reset; rdy_in low freezes every register
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state      <= StIdle;
            r_pc         <= RESET_PC;
            r_discard    <= 1'b0;
            r_mc_re      <= 1'b0;
            r_mc_addr    <= 32'h0000_0000;
            r_inst_valid <= 1'b0;
            r_inst       <= 32'h0000_0000;
            r_pc_out     <= 32'h0000_0000;
        end else if (rdy_in) begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_discard    <= w_discard_nxt;
            r_mc_re      <= w_mc_re_nxt;
            r_mc_addr    <= w_mc_addr_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_inst       <= w_inst_nxt;
            r_pc_out     <= w_pc_out_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mc_re_out      = r_mc_re;
    assign mc_addr_out    = r_mc_addr;
    assign mc_len_out     = 3'd4;
    assign inst_valid_out = r_inst_valid;
    assign inst_out       = r_inst;
    assign pc_out         = r_pc_out;

endmodule

// File: tb/tb_if_fetch.sv
// Directed testbench for if_fetch with a small memory-controller model
// (request sampled on the ISSUE edge, done pulse in the 5th controller cycle).

module tb_if_fetch;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        mc_re;
    logic [31:0] mc_addr;
    logic [2:0]  mc_len;
    logic        mc_busy;
    logic        mc_done;
    logic [31:0] mc_data;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc_o;
    logic        flush;
    logic [31:0] flush_pc;

    int vectors     = 0;
    int miscompares = 0;

    if_fetch #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .rdy_in         (rdy),
        .mc_re_out      (mc_re),
        .mc_addr_out    (mc_addr),
        .mc_len_out     (mc_len),
        .mc_busy_in     (mc_busy),
        .mc_done_in     (mc_done),
        .mc_r_data_in   (mc_data),
        .id_stall_in    (stall),
        .inst_valid_out (inst_valid),
        .inst_out       (inst),
        .pc_out         (pc_o),
        .flush_in       (flush),
        .flush_pc_in    (flush_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0013;
            32'h0000_0004: return 32'h0010_0093;
            32'h0000_0008: return 32'h0020_0113;
            32'h0000_0104: return 32'hDEAD_BEEF;
            default:       return 32'hA000_0000 | a;
        endcase
    endfunction

    // Controller model: accepts re on an edge, pulses done 4 edges later
    int          mc_cnt = 0;
    logic [31:0] mc_req_addr = 32'h0;
    initial begin
        mc_busy = 1'b0;
        mc_done = 1'b0;
        mc_data = 32'h0;
    end
    always @(posedge clk) begin
        logic        s_re;
        logic        s_rdy;
        logic        s_rst;
        logic [31:0] s_addr;
        s_re   = mc_re;
        s_rdy  = rdy;
        s_rst  = rst_n;
        s_addr = mc_addr;
        #1;
        if (!s_rst) begin
            mc_cnt  = 0;
            mc_done = 1'b0;
            mc_busy = 1'b0;
        end else if (s_rdy) begin
            if (mc_cnt != 0) mc_cnt = mc_cnt - 1;
            if (s_re && mc_cnt == 0) begin
                mc_cnt      = 5;
                mc_req_addr = s_addr;
            end
            mc_done = (mc_cnt == 1);
            mc_data = mc_done ? mem_word(mc_req_addr) : 32'h0;
            mc_busy = (mc_cnt != 0);
        end
    end

    // Request-pulse and valid-cycle counters
    int   re_cnt = 0;
    int   re_double = 0;
    int   valid_cnt = 0;
    logic re_prev = 1'b0;
    always @(negedge clk) begin
        if (mc_re) re_cnt = re_cnt + 1;
        if (mc_re && re_prev) re_double = re_double + 1;
        re_prev = mc_re;
        if (inst_valid) valid_cnt = valid_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_re(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mc_re && n < 60);
        check({tag, "_re_seen"}, {31'b0, mc_re}, 32'd1);
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!inst_valid && n < 60);
        check({tag, "_valid_seen"}, {31'b0, inst_valid}, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mc_done && n < 60);
        check({tag, "_done_seen"}, {31'b0, mc_done}, 32'd1);
    endtask

    initial begin
        int n;
        int total;
        int snap;
        rst_n    = 1'b0;
        rdy      = 1'b1;
        stall    = 1'b0;
        flush    = 1'b0;
        flush_pc = 32'h0;
        step(3);

        // Reset state
        check("rst_re",    {31'b0, mc_re}, 32'd0);
        check("rst_addr",  mc_addr, 32'h0);
        check("rst_len",   {29'b0, mc_len}, 32'd4);
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst",  inst, 32'h0);
        check("rst_pc",    pc_o, 32'h0);
        rst_n = 1'b1;

        // First fetch: single pulse at 0, len 4, delivered 6 cycles after request
        wait_re("f0", n);
        check("f0_addr", mc_addr, 32'h0);
        check("f0_len",  {29'b0, mc_len}, 32'd4);
        step(1);
        check("f0_re_single", {31'b0, mc_re}, 32'd0);
        wait_valid("f0", n);
        check("f0_latency", n + 1, 32'd6);
        check("f0_inst", inst, 32'h0000_0013);
        check("f0_pc",   pc_o, 32'h0);

        // Next request follows at 4
        wait_re("f1", n);
        check("f1_addr", mc_addr, 32'h4);

        // Stall holds the buffer and blocks new requests
        wait_valid("f1", n);
        stall = 1'b1;
        snap  = re_cnt;
        step(10);
        check("stall_valid", {31'b0, inst_valid}, 32'd1);
        check("stall_inst",  inst, 32'h0010_0093);
        check("stall_pc",    pc_o, 32'h4);
        check("stall_no_re", re_cnt, snap);
        stall = 1'b0;
        step(1);
        check("unstall_valid", {31'b0, inst_valid}, 32'd0);
        check("unstall_re",    {31'b0, mc_re}, 32'd1);
        check("unstall_addr",  mc_addr, 32'h8);

        // Flush to 0x107 while waiting on the 0x8 read
        step(2);
        flush    = 1'b1;
        flush_pc = 32'h0000_0107;
        step(1);
        flush = 1'b0;
        snap  = valid_cnt;
        wait_re("fl", n);
        check("fl_addr", mc_addr, 32'h104);
        check("fl_dropped", valid_cnt, snap);
        wait_valid("fl", n);
        check("fl_inst", inst, 32'hDEAD_BEEF);
        check("fl_pc",   pc_o, 32'h104);

        // Flush coincident with done of the 0x108 read
        wait_done("fd");
        flush    = 1'b1;
        flush_pc = 32'h0000_0200;
        step(1);
        flush = 1'b0;
        check("fd_valid", {31'b0, inst_valid}, 32'd0);
        snap = valid_cnt;
        wait_re("fd", n);
        check("fd_addr", mc_addr, 32'h200);
        check("fd_dropped", valid_cnt, snap);

        // rdy low for 3 cycles mid-WAIT delays delivery by 3
        step(2);
        rdy = 1'b0;
        step(3);
        check("rdy_hold_re",    {31'b0, mc_re}, 32'd0);
        check("rdy_hold_valid", {31'b0, inst_valid}, 32'd0);
        rdy = 1'b1;
        wait_valid("rdy", n);
        total = 5 + n;
        check("rdy_latency", total, 32'd9);
        check("rdy_inst", inst, 32'hA000_0200);
        check("rdy_pc",   pc_o, 32'h200);

        // PC wrap from FFFF_FFFC to 0
        wait_re("w0", n);
        step(1);
        flush    = 1'b1;
        flush_pc = 32'hFFFF_FFFF;
        step(1);
        flush = 1'b0;
        wait_re("wr", n);
        check("wr_addr", mc_addr, 32'hFFFF_FFFC);
        wait_valid("wr", n);
        check("wr_inst", inst, 32'hFFFF_FFFC);
        check("wr_pc",   pc_o, 32'hFFFF_FFFC);
        wait_re("wz", n);
        check("wz_addr", mc_addr, 32'h0);
        wait_valid("wz", n);
        check("wz_inst", inst, 32'h0000_0013);
        check("wz_pc",   pc_o, 32'h0);

`ifdef ICACHE_EN
        // Loop 0x40..0x4C: first pass through the controller, second from cache
        wait_re("c0", n);
        step(1);
        flush    = 1'b1;
        flush_pc = 32'h0000_0040;
        step(1);
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_valid("cmiss", n);
            check("cmiss_pc",   pc_o, 32'h40 + 32'(4 * i));
            check("cmiss_inst", inst, 32'hA000_0040 + 32'(4 * i));
        end
        stall    = 1'b1;
        flush    = 1'b1;
        flush_pc = 32'h0000_0040;
        step(1);
        flush = 1'b0;
        stall = 1'b0;
        snap  = re_cnt;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("chit_valid", {31'b0, inst_valid}, 32'd1);
            check("chit_pc",    pc_o, 32'h40 + 32'(4 * i));
            check("chit_inst",  inst, 32'hA000_0040 + 32'(4 * i));
        end
        check("chit_no_re", re_cnt, snap);
        wait_re("cnext", n);
        check("cnext_addr", mc_addr, 32'h50);
`endif

        step(2);
        check("re_never_double", re_double, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
